dbus_arb: RTL
=============

// Module: dbus_arb
// PURPOSE
//  Two-master arbiter in front of dbus_conn. Shares the single data-bus master port between:
//   - m0: core load/store unit
//   - m1: debug/DMA master
//  Zero-latency grant in IDLE; the grant is held until the slave responds or faults.
//  Round-robin (or fixed-priority) on contention, plus a debug exclusive-access lock.
// PARAMETERS
//  RR_EN  1  1: round-robin on simultaneous requests; 0: fixed priority, m1 beats m0.
// PORTS
//  clk        in   1                      clock
//  rstn       in   1                      reset, asynchronous, active-low
//  excl       in   1                      1: m1 exclusive, m0 not granted in IDLE
//  m0_req     in   1                      m0 request, held with attrs until m0_resp/m0_fault
//  m0_addr    in   `XLEN                  m0 address
//  m0_w_rb    in   1                      m0 write(1)/read(0)
//  m0_acc     in   $clog2(`BUS_ACC_CNT)   m0 access size
//  m0_wdata   in   `BUS_WIDTH             m0 write data
//  m0_resp    out  1                      m0 transfer done (1-cycle pulse)
//  m0_rdata   out  `BUS_WIDTH             = s_rdata
//  m0_fault   out  1                      m0 transfer hit unmapped address (1-cycle pulse)
//  m1_*       same set as m0_*            debug/DMA master
//  s_req, s_addr, s_w_rb, s_acc, s_wdata   out  to dbus_conn m_* (mux of granted master)
//  s_resp     in   1                      dbus_conn m_resp
//  s_rdata    in   `BUS_WIDTH             dbus_conn m_rdata
//  s_fault    in   1                      dbus_conn bus_fault (same cycle as s_req)
//  gnt        out  1                      current owner: 0=m0, 1=m1 (debug visibility)
// BEHAVIOUR
//  - State regs: st{IDLE,BUSY}, owner, last_gnt.
//    Reset (rstn low, async): st=IDLE, owner=0, last_gnt=1.
//    With no requests after reset: s_req=0, m*_resp=0, m*_fault=0, gnt=0.
//  - IDLE winner (combinational):
//    - only m0_req & ~excl -> m0; only m1_req -> m1.
//    - both eligible: RR_EN=1 -> ~last_gnt; RR_EN=0 -> m1.
//    - excl=1: m0 ineligible in IDLE.
//  - IDLE with a winner: s_* = winner attrs and s_req=1 in the same cycle. gnt=winner.
//    - s_resp=1: pulse winner resp; last_gnt<=winner; stay IDLE.
//    - s_fault=1: pulse winner fault, no resp; last_gnt<=winner; stay IDLE.
//    - neither: owner<=winner; st<=BUSY.
//  - BUSY: s_* = owner attrs, s_req = owner req; gnt=owner. Other master ignored; excl changes ignored.
//    - s_resp: pulse owner resp; last_gnt<=owner; st<=IDLE. The next grant is evaluated in the following cycle, so at most one transfer completes per cycle.
//    - s_fault: pulse owner fault; last_gnt<=owner; st<=IDLE.
//    - Owner dropping req in BUSY is illegal; the arbiter still returns to IDLE on s_resp.
//  - m*_resp and m*_fault only to the granted master; the non-owner sees 0. rdata is shared unmuxed.
//  - Back-to-back: a master holding req after its resp re-arbitrates from IDLE. With RR_EN=1 and both requesting, grants alternate.
//  - Latency adds 0 cycles in IDLE. The cycle after a multi-cycle completion is IDLE and can grant the other master.
//  - rstn asserted mid-transfer: immediate IDLE, no resp/fault emitted. A pending slave transfer is abandoned; the system resets slaves together.
// TESTING
//  1. m0 read 0x2000_0000 alone, s_resp same cycle, s_rdata=0x1234_5678
//     -> m0_resp=1, m0_rdata=0x1234_5678 in that cycle; st stays IDLE.
//  2. m0,m1 req same cycle after reset, RR_EN=1, each slave takes 2 cycles
//     -> m0 served first, m1 granted the cycle after m0_resp; m0 next after m1.
//  3. m1 granted, slave stalls 5 cycles while m0 asserts req
//     -> s_addr stays m1_addr for all 5 cycles; m0_resp=0 throughout; m0 granted next.
//  4. excl=1, m0 and m1 both requesting repeatedly -> only m1 granted.
//     excl=1 raised while m0 BUSY -> m0 completes, then m0 blocked.
//  5. m0 addr 0xF000_0000, s_fault=1 in request cycle
//     -> m0_fault pulse, m0_resp=0, st IDLE, last_gnt=0.
//  6. rstn low during BUSY -> st=IDLE, no resp pulse; first grant after release goes to m0 on tie.

Source files
------------

// File: rtl/dbus_arb.sv
// dbus_arb -- two-master arbiter in front of dbus_conn.
//
// Shares the single data-bus master port between the core load/store unit
// (m0) and the debug/DMA master (m1). In IDLE a requesting master is granted
// in the same cycle it asks, so single-cycle slaves add no latency. The grant
// is then held (BUSY) until the slave answers with s_resp or s_fault.
// Contention is settled by round-robin (RR_EN=1) or by a fixed priority where
// m1 wins (RR_EN=0). While excl is high, m0 cannot win a new grant. A
// transfer that is already running is not interrupted by excl.
//
// Ports
//   clk, rstn                  clock, asynchronous active-low reset
//   excl                       debug exclusive access: block new m0 grants
//   m0_req/addr/w_rb/acc/wdata m0 request and attributes, held until done
//   m0_resp, m0_fault          m0 completion / bus fault (1-cycle pulses)
//   m0_rdata                   read data (s_rdata, shared)
//   m1_*                       same set for the debug/DMA master
//   s_req/addr/w_rb/acc/wdata  to dbus_conn, attributes of the granted master
//   s_resp, s_rdata, s_fault   from dbus_conn
//   gnt                        current owner, 0=m0 1=m1 (debug visibility)
module dbus_arb #(
    parameter int RR_EN       = 1,
    parameter int XLEN        = 32,
    parameter int BUS_WIDTH   = 32,
    parameter int BUS_ACC_CNT = 4,
    parameter int ACC_W       = $clog2(BUS_ACC_CNT)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 excl,

    input  logic                 m0_req,
    input  logic [XLEN-1:0]      m0_addr,
    input  logic                 m0_w_rb,
    input  logic [ACC_W-1:0]     m0_acc,
    input  logic [BUS_WIDTH-1:0] m0_wdata,
    output logic                 m0_resp,
    output logic [BUS_WIDTH-1:0] m0_rdata,
    output logic                 m0_fault,

    input  logic                 m1_req,
    input  logic [XLEN-1:0]      m1_addr,
    input  logic                 m1_w_rb,
    input  logic [ACC_W-1:0]     m1_acc,
    input  logic [BUS_WIDTH-1:0] m1_wdata,
    output logic                 m1_resp,
    output logic [BUS_WIDTH-1:0] m1_rdata,
    output logic                 m1_fault,

    output logic                 s_req,
    output logic [XLEN-1:0]      s_addr,
    output logic                 s_w_rb,
    output logic [ACC_W-1:0]     s_acc,
    output logic [BUS_WIDTH-1:0] s_wdata,
    input  logic                 s_resp,
    input  logic [BUS_WIDTH-1:0] s_rdata,
    input  logic                 s_fault,

    output logic                 gnt
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t st;
    logic   owner;
    logic   last_gnt;

    logic   busy;
    logic   m0_elig;
    logic   m1_elig;
    logic   idle_valid;
    logic   idle_win;
    logic   sel;
    logic   xfer;
    logic   done_ok;
    logic   done_flt;

    assign busy    = (st == BUSY);
    assign m0_elig = m0_req & ~excl;
    assign m1_elig = m1_req;

    // On a tie the master that did not finish last wins under round-robin,
    // otherwise m1 always wins. With one eligible master, m1_elig alone
    // tells which one it is (and gives 0 when nobody is eligible).
    assign idle_valid = m0_elig | m1_elig;
    assign idle_win   = (m0_elig & m1_elig) ? ((RR_EN != 0) ? ~last_gnt : 1'b1)
                                            : m1_elig;

    assign sel = busy ? owner : idle_win;
    assign gnt = sel;

    // xfer marks a cycle in which the granted master owns the slave port;
    // in BUSY this stays true even if the owner illegally drops req, so the
    // arbiter still returns to IDLE on the slave's answer.
    assign xfer  = busy | idle_valid;
    assign s_req = busy ? (owner ? m1_req : m0_req) : idle_valid;

    assign s_addr  = sel ? m1_addr  : m0_addr;
    assign s_w_rb  = sel ? m1_w_rb  : m0_w_rb;
    assign s_acc   = sel ? m1_acc   : m0_acc;
    assign s_wdata = sel ? m1_wdata : m0_wdata;

    // A fault replaces the response, never both.
    assign done_ok  = xfer & s_resp & ~s_fault;
    assign done_flt = xfer & s_fault;

    assign m0_resp  = done_ok  & ~sel;
    assign m1_resp  = done_ok  &  sel;
    assign m0_fault = done_flt & ~sel;
    assign m1_fault = done_flt &  sel;

    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;

    // last_gnt resets to 1 so the first tie after reset goes to m0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st       <= IDLE;
            owner    <= 1'b0;
            last_gnt <= 1'b1;
        end else begin
            case (st)
                IDLE: begin
                    if (idle_valid) begin
                        if (s_resp || s_fault) begin
                            last_gnt <= idle_win;
                        end else begin
                            owner <= idle_win;
                            st    <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (s_resp || s_fault) begin
                        last_gnt <= owner;
                        st       <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule
